// File: rtl/apb_rr_master_arbiter.sv
// Purpose : round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Latency : REQ->GNT 1 cycle from IDLE; GNT->DONE 2 cycles plus PREADY wait states (3-cycle bus period).
// Backpress: requesters hold REQ until GNT; the slave stalls with PREADY, bounded by TIMEOUT_CYCLES.
//
// Ports
//   M_CLK, RSTn          clock, async active-low reset
//   REQ/REQ_WRITE        per-requester request and direction (1=write)
//   REQ_ADDR/REQ_WDATA   packed per-requester address / write data, slot i at [i*W +: W]
//   GNT/DONE             one-cycle onehot pulses: request latched / transfer complete
//   RDATA/ERR/TIMEOUT    completion status, valid with DONE and held until the next DONE
//   PSEL..PSLVERR        APB master interface
module apb_rr_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          M_CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ-1:0]            REQ_WRITE,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            DONE,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic                          ERR,
  output logic                          TIMEOUT,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDRESS_WIDTH-1:0]      PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         last_gnt, last_gnt_nxt;
  logic [NUM_REQ-1:0]    cur_oh, cur_oh_nxt;     // owner of the transfer in flight
  logic [CW-1:0]         cnt, cnt_nxt;           // ACCESS cycles spent without PREADY

  logic [NUM_REQ-1:0]    gnt_nxt, done_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt, pwdata_nxt;
  logic [ADDRESS_WIDTH-1:0] paddr_nxt;
  logic                  err_nxt, timeout_nxt, psel_nxt, penable_nxt, pwrite_nxt;

  // Round-robin winner: walk forward from the slot after last_gnt, wrapping.
  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [NUM_REQ-1:0]    win_oh;
  logic [PW-1:0]         cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_gnt;
    win_oh    = '0;
    cand      = last_gnt;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == LAST_IDX) cand = '0;
      else                  cand = cand + 1'b1;
      if (!win_found && REQ[cand]) begin
        win_found    = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

  // Request fields of the winning slot.
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        sel_write = REQ_WRITE[k];
        sel_addr  = REQ_ADDR[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata = REQ_WDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every output is a register below.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    cur_oh_nxt   = cur_oh;
    cnt_nxt      = cnt;
    gnt_nxt      = '0;
    done_nxt     = '0;
    rdata_nxt    = RDATA;
    err_nxt      = ERR;
    timeout_nxt  = TIMEOUT;
    psel_nxt     = PSEL;
    penable_nxt  = PENABLE;
    pwrite_nxt   = PWRITE;
    paddr_nxt    = PADDR;
    pwdata_nxt   = PWDATA;

    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt      = win_oh;
          cur_oh_nxt   = win_oh;
          last_gnt_nxt = win_idx;
          pwrite_nxt   = sel_write;
          paddr_nxt    = sel_addr;
          pwdata_nxt   = sel_wdata;
          psel_nxt     = 1'b1;
          penable_nxt  = 1'b0;
          state_nxt    = SETUP;
        end
      end

      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          if (!PWRITE) rdata_nxt = PRDATA;
          err_nxt     = PSLVERR;
          timeout_nxt = 1'b0;
          done_nxt    = cur_oh;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (cnt == CNT_LAST) begin
          // Slave never answered: abort, RDATA keeps its previous value.
          err_nxt     = 1'b1;
          timeout_nxt = 1'b1;
          done_nxt    = cur_oh;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge M_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      last_gnt <= LAST_IDX;
      cur_oh   <= '0;
      cnt      <= '0;
      GNT      <= '0;
      DONE     <= '0;
      RDATA    <= '0;
      ERR      <= 1'b0;
      TIMEOUT  <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      cur_oh   <= cur_oh_nxt;
      cnt      <= cnt_nxt;
      GNT      <= gnt_nxt;
      DONE     <= done_nxt;
      RDATA    <= rdata_nxt;
      ERR      <= err_nxt;
      TIMEOUT  <= timeout_nxt;
      PSEL     <= psel_nxt;
      PENABLE  <= penable_nxt;
      PWRITE   <= pwrite_nxt;
      PADDR    <= paddr_nxt;
      PWDATA   <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Testbench for apb_rr_master_arbiter: directed vector table, reset/rotation
// sequences, then random requesters and slave against a transaction-level model.
module tb_apb_rr_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            M_CLK = 1'b0;
  logic            RSTn;
  logic [N-1:0]    REQ, REQ_WRITE;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA;
  logic [N-1:0]    GNT, DONE;
  logic [DW-1:0]   RDATA;
  logic            ERR, TIMEOUT, PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic            PREADY, PSLVERR;

  always #5 M_CLK = ~M_CLK;

  apb_rr_master_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_CLK(M_CLK), .RSTn(RSTn),
    .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .TIMEOUT(TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge M_CLK);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic drive_slot(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ[i]                = 1'b1;
    REQ_WRITE[i]          = wr;
    REQ_ADDR[i*AW +: AW]  = a;
    REQ_WDATA[i*DW +: DW] = d;
  endtask

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // -1: PREADY never rises
    logic [31:0] prdata;
    logic        slverr;
    int          exp_dly;    // cycles from GNT to DONE
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input int id, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits, input logic [31:0] prdata,
                              input logic slverr, input int dly, input logic e, input logic t,
                              input logic [31:0] rd);
    vec_t v;
    v.id = id; v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
    v.prdata = prdata; v.slverr = slverr; v.exp_dly = dly; v.exp_err = e;
    v.exp_to = t; v.exp_rdata = rd;
    return v;
  endfunction

  // One isolated transfer from an idle bus; the bench plays the APB slave.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    bit seen;
    string p;
    p = $sformatf("v%0d", idx);
    REQ = '0;
    drive_slot(v.id, v.wr, v.addr, v.wdata);
    PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    chk({p, "_gnt"}, GNT, onehot(v.id));
    chk({p, "_setup_psel"}, PSEL, 1);
    chk({p, "_setup_pen"}, PENABLE, 0);
    chk({p, "_paddr"}, PADDR, v.addr);
    chk({p, "_pwrite"}, PWRITE, v.wr);
    REQ = '0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      PREADY  = (v.waits >= 0 && n == 1 + v.waits);
      PRDATA  = PREADY ? v.prdata : (32'hDEAD_0000 | 32'(n));
      PSLVERR = PREADY ? v.slverr : 1'b1;
      tick();
      n++;
      if (n == 1) begin
        chk({p, "_gnt_pulse"}, GNT, 0);
        chk({p, "_access_psel"}, PSEL, 1);
        chk({p, "_access_pen"}, PENABLE, 1);
        chk({p, "_access_paddr"}, PADDR, v.addr);
        chk({p, "_access_pwdata"}, PWDATA, v.wdata);
      end
      if (DONE != '0) seen = 1'b1;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    chk({p, "_done_seen"}, seen, 1);
    chk({p, "_done_dly"}, n, v.exp_dly);
    chk({p, "_done"}, DONE, onehot(v.id));
    chk({p, "_err"}, ERR, v.exp_err);
    chk({p, "_timeout"}, TIMEOUT, v.exp_to);
    chk({p, "_rdata"}, RDATA, v.exp_rdata);
    chk({p, "_idle_psel"}, PSEL, 0);
    chk({p, "_idle_pen"}, PENABLE, 0);
    tick();
    chk({p, "_done_pulse"}, DONE, 0);
    chk({p, "_rdata_hold"}, RDATA, v.exp_rdata);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Random-phase model state
  bit              pend [N];
  logic            wr_a [N];
  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   wd_a [N];
  bit              act, t_wr, t_err, in_xfer, rdy;
  int              free_from, g_c, d_c, owner, waits, m_last, w, r, ng, last_c;
  logic [AW-1:0]   t_addr;
  logic [DW-1:0]   t_wd, t_prd, m_rdata;
  logic            m_err, m_to;
  logic [N-1:0]    req_prev, eg, ed;
  vec_t            vt [6];

  initial begin
    // ---------------- reset state ----------------
    RSTn = 1'b0;
    REQ = '1; REQ_WRITE = '1; REQ_ADDR = '1; REQ_WDATA = '1;
    PRDATA = '1; PREADY = 1'b1; PSLVERR = 1'b1;
    tick(); tick(); tick();
    chk("rst_gnt", GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_err", ERR, 0);
    chk("rst_timeout", TIMEOUT, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    RSTn = 1'b1;
    tick();

    // ---------------- directed vector table ----------------
    //          id wr  addr          wdata         waits prdata        err dly e  t  rdata
    vt[0] = mk(0, 1, 32'h10,        32'hABCD1234, 0,  32'h0,        0,  2,  0, 0, 32'h0);
    vt[1] = mk(1, 0, 32'h11,        32'h0,        3,  32'hBCDA1234, 0,  5,  0, 0, 32'hBCDA1234);
    vt[2] = mk(2, 0, 32'h20,        32'h1,        -1, 32'h55,       0,  17, 1, 1, 32'hBCDA1234);
    vt[3] = mk(3, 0, 32'h30,        32'h2,        0,  32'h600DF00D, 1,  2,  1, 0, 32'h600DF00D);
    vt[4] = mk(0, 1, 32'h44,        32'h12345678, 15, 32'h77,       0,  17, 0, 0, 32'h600DF00D);
    vt[5] = mk(1, 1, 32'h48,        32'hCAFEBABE, 1,  32'h99,       1,  3,  1, 0, 32'h600DF00D);
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vt[i]);
      tick();
    end

    // ---------------- reset mid-ACCESS, then rotation ----------------
    REQ = '0;
    drive_slot(2, 1'b0, 32'h2222_0000, 32'h0);
    tick();
    chk("ab_gnt", GNT, onehot(2));
    REQ = '0;
    tick();
    tick();
    chk("ab_in_access", PENABLE, 1);
    RSTn = 1'b0;
    #1;
    chk("ab_async_psel", PSEL, 0);
    chk("ab_async_pen", PENABLE, 0);
    for (int i = 0; i < N; i++) drive_slot(i, 1'b1, 32'h100 + 32'(i), 32'h5000 + 32'(i));
    PREADY = 1'b1; PSLVERR = 1'b0;
    tick();
    chk("ab_rst_done0", DONE, 0);
    tick();
    chk("ab_rst_done1", DONE, 0);
    RSTn = 1'b1;
    ng = 0; last_c = 0;
    for (int c = 1; c <= 40 && ng < 8; c++) begin
      tick();
      if (c < 3) chk("rr_no_stale_done", DONE, 0);
      if (GNT != '0) begin
        chk($sformatf("rr_order%0d", ng), GNT, onehot(ng % N));
        if (ng == 0) chk("rr_first_lat", c, 1);
        else         chk($sformatf("rr_period%0d", ng), c - last_c, 3);
        last_c = c;
        ng++;
        if (ng == 8) REQ = '0;
      end
    end
    chk("rr_count", ng, 8);
    REQ = '0; PREADY = 1'b0;

    // ---------------- random phase against transaction model ----------------
    RSTn = 1'b0;
    tick(); tick();
    RSTn = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; wr_a[i] = 1'b0; addr_a[i] = '0; wd_a[i] = '0;
    end
    act = 1'b0; free_from = 0; m_last = N - 1;
    m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
    g_c = 0; d_c = 0; owner = 0; waits = 0;
    t_wr = 1'b0; t_err = 1'b0; t_addr = '0; t_wd = '0; t_prd = '0;
    for (int cyc = 1; cyc <= 2500; cyc++) begin
      req_prev = REQ;
      tick();
      eg = '0; ed = '0;
      // Arbiter was IDLE in the previous cycle: rotate from the last winner.
      if (cyc - 1 >= free_from && req_prev != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_prev[(m_last + k) % N]) w = (m_last + k) % N;
        eg[w] = 1'b1;
        act = 1'b1; owner = w; m_last = w; g_c = cyc;
        t_wr = wr_a[w]; t_addr = addr_a[w]; t_wd = wd_a[w];
        r = int'($urandom_range(0, 9));
        if (r < 7)      waits = int'($urandom_range(0, 3));
        else if (r < 9) waits = int'($urandom_range(4, TO - 1));
        else            waits = -1;
        d_c = (waits >= 0) ? cyc + 2 + waits : cyc + 1 + TO;
        free_from = d_c;
        t_prd = $urandom;
        t_err = ($urandom_range(0, 5) == 0);
      end
      if (act && cyc == d_c) begin
        ed[owner] = 1'b1;
        if (waits < 0) begin
          m_err = 1'b1; m_to = 1'b1;
        end else begin
          m_err = t_err; m_to = 1'b0;
          if (!t_wr) m_rdata = t_prd;
        end
      end
      chk("rnd_gnt", GNT, eg);
      chk("rnd_done", DONE, ed);
      in_xfer = act && cyc >= g_c && cyc < d_c;
      chk("rnd_psel", PSEL, in_xfer);
      chk("rnd_penable", PENABLE, in_xfer && cyc > g_c);
      if (in_xfer) begin
        chk("rnd_paddr", PADDR, t_addr);
        chk("rnd_pwrite", PWRITE, t_wr);
        chk("rnd_pwdata", PWDATA, t_wd);
      end
      chk("rnd_err", ERR, m_err);
      chk("rnd_timeout", TIMEOUT, m_to);
      chk("rnd_rdata", RDATA, m_rdata);
      if (act && cyc == d_c) act = 1'b0;

      // Slave for this cycle
      rdy = act && waits >= 0 && cyc == g_c + 1 + waits;
      PREADY  = rdy;
      PRDATA  = rdy ? t_prd : $urandom;
      PSLVERR = rdy ? t_err : 1'($urandom_range(0, 1));

      // Requesters: drop on grant, occasionally withdraw, raise when free
      for (int i = 0; i < N; i++) begin
        if (eg[i]) pend[i] = 1'b0;
        else if (pend[i]) begin
          if ($urandom_range(0, 24) == 0) pend[i] = 1'b0;
        end else if (!(act && owner == i) && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          wr_a[i]   = 1'($urandom_range(0, 1));
          addr_a[i] = $urandom;
          wd_a[i]   = $urandom;
        end
        REQ[i]                = pend[i];
        REQ_WRITE[i]          = wr_a[i];
        REQ_ADDR[i*AW +: AW]  = addr_a[i];
        REQ_WDATA[i*DW +: DW] = wd_a[i];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
